sysid_probe_master: RTL
=======================

// Module: sysid_probe_master
// PURPOSE
// - Avalon-MM read master that interrogates a system-ID slave: reads ID word (offset 0x0) and timestamp word (offset 0x4).
// - Compares both against build-time expected values; reports match/mismatch/timeout to the boot or health-monitor logic.
// - Sits beside the processor on the interconnect so hardware/software version mismatch is flagged without firmware involvement.
// PARAMETERS
// - ADDR_WIDTH         32            byte-address width of avm_address
// - BASE_ADDR          32'h0000_0000 base byte address of the sysid slave
// - EXPECTED_ID        32'h0000_0000 expected system-ID word
// - EXPECTED_TS        32'd1673199811 expected timestamp word
// - USE_READDATAVALID  1             1: data on avm_readdatavalid; 0: data valid in accept cycle (read && !waitrequest)
// - TIMEOUT_CYCLES     255           max cycles per read phase (issue to data) before abort; 8-bit counter
// PORTS
// - clock              in   1   sole clock; all logic rising-edge
// - reset              in   1   synchronous, active-high reset
// - start              in   1   one-cycle pulse: begin probe (ignored while busy)
// - avm_address        out  ADDR_WIDTH  byte address of current read
// - avm_read           out  1   read request
// - avm_waitrequest    in   1   slave stall; request held while high
// - avm_readdata       in   32  read data
// - avm_readdatavalid  in   1   read data strobe (ignored if USE_READDATAVALID=0)
// - busy               out  1   probe in progress
// - done               out  1   one-cycle pulse at probe completion
// - id_ok              out  1   captured ID == EXPECTED_ID (sticky until next start)
// - ts_ok              out  1   captured timestamp == EXPECTED_TS (sticky until next start)
// - timeout            out  1   a phase exceeded TIMEOUT_CYCLES (sticky until next start)
// - id_value           out  32  captured ID word
// - ts_value           out  32  captured timestamp word
// BEHAVIOUR
// - Interface: one clock (clock); reset is synchronous and active-high (reset).
// - Reset: state IDLE; avm_read=0, avm_address=BASE_ADDR, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0.
// - Reset mid-probe: next edge returns to IDLE with above values; an outstanding response arriving afterwards is ignored.
// - FSM: IDLE -> RD_ID -> WT_ID -> RD_TS -> WT_TS -> DONE -> IDLE.
// - IDLE: start=1 -> RD_ID; clear id_ok/ts_ok/timeout/id_value/ts_value; busy=1 from next cycle.
// - RD_ID: avm_read=1, avm_address=BASE_ADDR; address/read held stable while avm_waitrequest=1.
//   Accept (read && !waitrequest): deassert read next cycle; go WT_ID, or straight to RD_TS if data captured in accept cycle.
// - Capture: USE_READDATAVALID=1 -> on readdatavalid in RD_x (same-cycle as accept) or WT_x; =0 -> in accept cycle, WT_x skipped.
// - RD_TS/WT_TS identical with address BASE_ADDR+4, capture into ts_value.
// - Compare registered at capture: id_ok <= (readdata==EXPECTED_ID); ts_ok <= (readdata==EXPECTED_TS).
// - Timeout: 8-bit counter cleared on entry to each RD_x, increments each cycle in RD_x/WT_x; reaching TIMEOUT_CYCLES
//   -> timeout=1, avm_read=0, go DONE (remaining phase skipped, its ok flag stays 0). Counter saturates, never wraps.
// - DONE: done=1 for exactly one cycle, busy=0 in the same cycle; -> IDLE. Latency with zero-wait slave, USE_READDATAVALID=0:
//   start at cycle 0 -> done at cycle 3.
// - start while busy or in DONE: ignored. start in IDLE the cycle after DONE: accepted.
// - Never more than one outstanding read; avm_read never asserted outside RD_x.
// STRUCTURE
// - Shared package: FSM state enum (IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE), SYSID_ID_OFFSET=0x0, SYSID_TS_OFFSET=0x4.
// - No sub-module; single FSM + timeout counter + two capture registers.
// TESTING
// - Zero-wait slave (ID=0, TS=1673199811), USE_READDATAVALID=0, start -> reads at 0x0 then 0x4, done at cycle 3, id_ok=1, ts_ok=1.
// - waitrequest high 5 cycles on ID read -> avm_address/avm_read stable all 5 cycles; exactly one accept; results correct.
// - USE_READDATAVALID=1, readdatavalid 3 cycles after accept -> ID captured only on strobe; stray strobe in IDLE ignored.
// - Slave returns TS=0x12345678 -> id_ok=1, ts_ok=0, ts_value=0x12345678, timeout=0.
// - waitrequest stuck high, TIMEOUT_CYCLES=16 -> timeout=1 and done after 16 cycles in RD_ID, avm_read=0, id_ok=ts_ok=0.
// - reset asserted in WT_TS, then start pulsed while busy -> back to IDLE all outputs zero; busy-start ignored, fresh probe passes.

Source files
------------

// File: rtl/sysid_probe_master_pkg.sv
`default_nettype none
// ============================================================================
// sysid_probe_master_pkg : probe FSM states and sysid slave register offsets
// Rev 1.0
// ============================================================================
package sysid_probe_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [31:0] SYSID_ID_OFFSET = 32'h0000_0000;
  localparam logic [31:0] SYSID_TS_OFFSET = 32'h0000_0004;

endpackage
`default_nettype wire

// File: rtl/sysid_probe_master.sv
`default_nettype none
// ============================================================================
// sysid_probe_master : Avalon-MM reader that checks sysid ID/timestamp words
// Rev 1.0
// ============================================================================
module sysid_probe_master
  import sysid_probe_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID       = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS       = 32'd1673199811,
  parameter bit          USE_READDATAVALID = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  busy,
  output logic                  done,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

  logic        accept;
  logic        cap_rd;
  logic        cap_wt;
  logic        expired;
  logic        in_rd;
  logic        in_ts;
  logic [7:0]  cnt_inc;

  assign accept = avm_read & ~avm_waitrequest;

  // cap_rd: data arrives in the accept cycle; cap_wt: data arrives later
  generate
    if (USE_READDATAVALID) begin : g_rdv
      assign cap_rd = accept & avm_readdatavalid;
      assign cap_wt = avm_readdatavalid;
    end else begin : g_accept
      logic unused_rdv;
      assign unused_rdv = avm_readdatavalid;
      assign cap_rd     = accept;
      assign cap_wt     = 1'b0;
    end
  endgenerate

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign expired = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYCLES);
  assign in_rd   = (state_q == RD_ID) || (state_q == RD_TS);
  assign in_ts   = (state_q == RD_TS) || (state_q == WT_TS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    id_val_d  = id_val_q;
    ts_val_d  = ts_val_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          cnt_d     = 8'd0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          id_val_d  = 32'd0;
          ts_val_d  = 32'd0;
        end
      end
      RD_ID, WT_ID: begin
        cnt_d = cnt_inc;
        if (in_rd ? cap_rd : cap_wt) begin
          id_val_d = avm_readdata;
          id_ok_d  = (avm_readdata == EXPECTED_ID);
          cnt_d    = 8'd0;
          state_d  = RD_TS;
        end else if (in_rd && accept) begin
          state_d = WT_ID;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      RD_TS, WT_TS: begin
        cnt_d = cnt_inc;
        if (in_rd ? cap_rd : cap_wt) begin
          ts_val_d = avm_readdata;
          ts_ok_d  = (avm_readdata == EXPECTED_TS);
          state_d  = DONE;
        end else if (in_rd && accept) begin
          state_d = WT_TS;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_val_q  <= 32'd0;
      ts_val_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      id_val_q  <= id_val_d;
      ts_val_q  <= ts_val_d;
    end
  end

  assign avm_read    = in_rd;
  assign avm_address = ADDR_WIDTH'(BASE_ADDR + (in_ts ? SYSID_TS_OFFSET : SYSID_ID_OFFSET));
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule
`default_nettype wire
